// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - selects a CPU statistic with a debounced button and scans it onto an 8-digit 7-segment display
module seg_display_scan #(
  parameter int SCAN_DIV        = 17,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] led_data_in,
  input  logic        led_cpu_enable,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] bubble_num,
  input  logic        mode_btn,
  output logic [2:0]  mode,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    M_LED    = 3'd0,
    M_TOTAL  = 3'd1,
    M_UNCOND = 3'd2,
    M_COND   = 3'd3,
    M_BUBBLE = 3'd4
  } mode_t;

  mode_t               state;
  logic                mode_chg;
  logic [SCAN_DIV-1:0] presc;
  logic [2:0]          idx;
  logic [31:0]         disp;
  logic [31:0]         hold;
  logic [31:0]         src;
  logic                btn_s1, btn_s2, stable;
  logic [CW-1:0]       cnt;
  logic                tick, settle, adv;
  logic [3:0]          nib;

  assign tick   = &presc;
  assign settle = (btn_s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign adv    = settle && btn_s2;

  // Synchronizer and debounce; only a settled press (0->1) advances the mode
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      btn_s1 <= mode_btn;
      btn_s2 <= btn_s1;
      if (btn_s2 == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= btn_s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= M_LED;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= adv;
      if (adv) begin
        case (state)
          M_LED:    state <= M_TOTAL;
          M_TOTAL:  state <= M_UNCOND;
          M_UNCOND: state <= M_COND;
          M_COND:   state <= M_BUBBLE;
          default:  state <= M_LED;
        endcase
      end
    end
  end

  assign mode = state;

  always_comb begin
    src = 32'h0;
    case (state)
      M_LED:    src = hold;
      M_TOTAL:  src = total_cycles;
      M_UNCOND: src = uncondi_branch_num;
      M_COND:   src = condi_branch_num;
      M_BUBBLE: src = bubble_num;
      default:  src = 32'h0;
    endcase
  end

  // Reload only at frame end or right after a mode change so a frame never mixes two samples
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 3'd0;
      disp  <= 32'h0;
      hold  <= 32'h0;
    end else begin
      presc <= presc + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if ((tick && idx == 3'd7) || mode_chg) disp <= src;
      if (led_cpu_enable) hold <= led_data_in;
    end
  end

  assign nib    = disp[{idx, 2'b00} +: 4];
  assign seg_an = ~(8'b1 << idx);

  always_comb begin
    seg_cat = 8'hFF;
    case (nib)
      4'h0: seg_cat[6:0] = 7'h40;
      4'h1: seg_cat[6:0] = 7'h79;
      4'h2: seg_cat[6:0] = 7'h24;
      4'h3: seg_cat[6:0] = 7'h30;
      4'h4: seg_cat[6:0] = 7'h19;
      4'h5: seg_cat[6:0] = 7'h12;
      4'h6: seg_cat[6:0] = 7'h02;
      4'h7: seg_cat[6:0] = 7'h78;
      4'h8: seg_cat[6:0] = 7'h00;
      4'h9: seg_cat[6:0] = 7'h10;
      4'hA: seg_cat[6:0] = 7'h08;
      4'hB: seg_cat[6:0] = 7'h03;
      4'hC: seg_cat[6:0] = 7'h46;
      4'hD: seg_cat[6:0] = 7'h21;
      4'hE: seg_cat[6:0] = 7'h06;
      default: seg_cat[6:0] = 7'h0E;
    endcase
    seg_cat[7] = !(idx == 3'd7 && state != M_LED);
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - bench for seg_display_scan with a cycle model plus directed literal checks
module tb_seg_display_scan;
  localparam int SD    = 2;
  localparam int DB    = 3;
  localparam int FRAME = 8 << SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] led_data_in = 32'h0;
  logic        led_cpu_enable = 1'b0;
  logic [31:0] total_cycles = 32'h0;
  logic [31:0] uncondi_branch_num = 32'h0;
  logic [31:0] condi_branch_num = 32'h0;
  logic [31:0] bubble_num = 32'h0;
  logic        mode_btn = 1'b0;
  logic [2:0]  mode;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int total = 0;
  int bad   = 0;

  seg_display_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .led_data_in(led_data_in), .led_cpu_enable(led_cpu_enable),
    .total_cycles(total_cycles), .uncondi_branch_num(uncondi_branch_num),
    .condi_branch_num(condi_branch_num), .bubble_num(bubble_num),
    .mode_btn(mode_btn), .mode(mode), .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: scan position derived from cycles since reset, button as a delayed level with a run length
  int          m_cyc = 0, m_run = 0, m_mode = 0;
  logic        m_stable = 1'b0, m_chg = 1'b0, chk_en = 1'b0;
  logic [1:0]  m_sync = 2'b00;
  logic [31:0] m_hold = 32'h0, m_disp = 32'h0;

  function automatic logic [31:0] src_of(int md);
    case (md)
      0: return m_hold;
      1: return total_cycles;
      2: return uncondi_branch_num;
      3: return condi_branch_num;
      default: return bubble_num;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_run = 0; m_mode = 0; m_stable = 1'b0; m_chg = 1'b0;
      m_sync = 2'b00; m_hold = 32'h0; m_disp = 32'h0;
    end else begin
      if (m_chg || (m_cyc % FRAME) == FRAME - 1) m_disp = src_of(m_mode);
      m_chg = 1'b0;
      if (m_sync[1] != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = ~m_stable;
          m_run = 0;
          if (m_stable) begin
            m_mode = (m_mode + 1) % 5;
            m_chg = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_sync = {m_sync[0], mode_btn};
      if (led_cpu_enable) m_hold = led_data_in;
      m_cyc++;
    end
    chk_en = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      logic [3:0] nib;
      logic [7:0] e_cat;
      idx   = (m_cyc >> SD) & 7;
      nib   = m_disp[4*idx +: 4];
      e_cat = {~(idx == 7 && m_mode != 0), seg_tab[nib][6:0]};
      chk("model_an", {24'h0, seg_an}, {24'h0, ~(8'b1 << idx)});
      chk("model_cat", {24'h0, seg_cat}, {24'h0, e_cat});
      chk("model_mode", {29'h0, mode}, m_mode[31:0]);
    end
  end

  task automatic wait_an(input logic [7:0] v, input string nm);
    int n = 0;
    while (seg_an !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {24'h0, seg_an}, {24'h0, v});
  endtask

  task automatic press();
    mode_btn = 1'b1;
    repeat (6) @(negedge clk);
    mode_btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    // Reset and scan stepping
    repeat (2) @(negedge clk);
    chk("rst_an", {24'h0, seg_an}, 32'hFE);
    chk("rst_cat", {24'h0, seg_cat}, 32'hC0);
    chk("rst_mode", {29'h0, mode}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("scan_hold", {24'h0, seg_an}, 32'hFE);
    @(negedge clk);
    chk("scan_fd", {24'h0, seg_an}, 32'hFD);
    repeat (24) @(negedge clk);
    chk("scan_7f", {24'h0, seg_an}, 32'h7F);
    repeat (4) @(negedge clk);
    chk("scan_wrap", {24'h0, seg_an}, 32'hFE);

    // LED hold path
    led_data_in = 32'h1234ABCD;
    led_cpu_enable = 1'b1;
    @(negedge clk);
    led_cpu_enable = 1'b0;
    led_data_in = 32'hFFFFFFFF;
    wait_an(8'h7F, "led_wait7");
    wait_an(8'hFE, "led_wait0");
    chk("led_d0", {24'h0, seg_cat}, 32'hA1);
    repeat (4) @(negedge clk);
    chk("led_d1", {24'h0, seg_cat}, 32'hC6);
    wait_an(8'h7F, "led_wait7b");
    chk("led_d7", {24'h0, seg_cat}, 32'hF9);

    // Debounce: short glitch, then a clean press
    mode_btn = 1'b1;
    repeat (2) @(negedge clk);
    mode_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_mode", {29'h0, mode}, 32'h0);
    mode_btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("press_early", {29'h0, mode}, 32'h0);
    @(negedge clk);
    chk("press_mode1", {29'h0, mode}, 32'h1);
    repeat (5) @(negedge clk);
    mode_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("press_single", {29'h0, mode}, 32'h1);

    // Mode wrap with bubble counter in mode 4
    bubble_num = 32'h5;
    press(); chk("wrap_2", {29'h0, mode}, 32'h2);
    press(); chk("wrap_3", {29'h0, mode}, 32'h3);
    press(); chk("wrap_4", {29'h0, mode}, 32'h4);
    wait_an(8'hFE, "bub_wait0");
    chk("bub_d0", {24'h0, seg_cat}, 32'h92);
    wait_an(8'h7F, "bub_wait7");
    chk("bub_d7", {24'h0, seg_cat}, 32'h40);
    press(); chk("wrap_0", {29'h0, mode}, 32'h0);

    // Live counter coherence in mode 1
    press(); chk("coh_mode1", {29'h0, mode}, 32'h1);
    for (int i = 0; i < 80; i++) begin
      total_cycles = $urandom;
      @(negedge clk);
    end
    total_cycles = 32'h7;
    wait_an(8'h7F, "coh_wait7");
    wait_an(8'hFE, "coh_wait0");
    chk("coh_d0", {24'h0, seg_cat}, 32'hF8);
    wait_an(8'h7F, "coh_wait7b");
    chk("coh_d7", {24'h0, seg_cat}, 32'h40);

    // Reset mid-debounce at digit 5
    wait_an(8'hDF, "mid_waitdf");
    wait_an(8'hEF, "mid_waitef");
    mode_btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_idx5", {24'h0, seg_an}, 32'hDF);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", {24'h0, seg_an}, 32'hFE);
    chk("mid_rst_mode", {29'h0, mode}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_no_adv", {29'h0, mode}, 32'h0);
    @(negedge clk);
    chk("mid_readv", {29'h0, mode}, 32'h1);
    mode_btn = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
